// File: rtl/bram_stream_reader_if.sv
// Signal bundle between bram_stream_reader and its surroundings:
// BRAM read port, burst control and the valid/ready output stream.
interface bram_stream_reader_if #(
  parameter int unsigned RAM_WIDTH = 16,
  parameter int unsigned AW        = 17
);
  // burst control
  logic                 start_in;
  logic [AW-1:0]        base_addr_in;
  logic [AW:0]          len_in;
  logic                 busy_out;
  logic                 done_out;

  // BRAM port
  logic [AW-1:0]        ram_addr_out;
  logic                 ram_en_out;
  logic                 ram_regce_out;
  logic                 ram_we_out;
  logic [RAM_WIDTH-1:0] ram_data_in;

  // output stream
  logic [RAM_WIDTH-1:0] data_out;
  logic                 valid_out;
  logic                 ready_in;
  logic                 last_out;

  modport master (
    input  start_in, base_addr_in, len_in, ram_data_in, ready_in,
    output ram_addr_out, ram_en_out, ram_regce_out, ram_we_out,
           data_out, valid_out, last_out, busy_out, done_out
  );

  modport slave (
    output start_in, base_addr_in, len_in, ram_data_in, ready_in,
    input  ram_addr_out, ram_en_out, ram_regce_out, ram_we_out,
           data_out, valid_out, last_out, busy_out, done_out
  );
endinterface

// File: rtl/bram_stream_reader.sv
// Burst reader for one BRAM port: issues LEN reads from BASE (wrapping at RAM_DEPTH) and
// streams the returned words out through a credit-tracked skid FIFO (FIFO_DEPTH slots + output register).
module bram_stream_reader #(
  parameter int unsigned RAM_WIDTH    = 16,
  parameter int unsigned RAM_DEPTH    = 76800,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input logic                  clk_in,
  input logic                  rst_in,
  bram_stream_reader_if.master bus
);

  localparam int unsigned AW  = $clog2(RAM_DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned CW  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW  = CW + 1;
  localparam int unsigned PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LAT = (READ_LATENCY > 0) ? READ_LATENCY : 1;
  localparam int unsigned EW  = RAM_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  state_e              state_q, state_d;

  // issue side
  logic [AW-1:0]       ram_addr_q, ram_addr_d;
  logic [AW-1:0]       next_addr_q, next_addr_d;
  logic [LW-1:0]       rem_q, rem_d;
  logic                en_q, en_d;
  logic                last_iss_q, last_iss_d;
  logic [AW-1:0]       issue_addr;
  logic [LW-1:0]       issue_left;

  // return pipe
  logic [LAT-1:0]      pipe_v_q;
  logic [LAT-1:0]      pipe_l_q;
  logic [CW-1:0]       inflight_q, inflight_d;

  // skid FIFO storage plus registered head
  logic [EW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [PW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [RAM_WIDTH-1:0] out_data_q, out_data_d;
  logic                out_last_q, out_last_d;

  logic                busy_q, done_q;

  logic                push, push_last, pop, out_free;
  logic                store_rd, store_wr;
  logic                credit_ok, fifo_overflow;
  logic [SW-1:0]       credit_sum;

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    return (a == AW'(RAM_DEPTH - 1)) ? '0 : a + AW'(1);
  endfunction

  // Datapath: return-pipe tap, FIFO push/pop routing, next-cycle credit
  always_comb begin
    push        = pipe_v_q[LAT-1];
    push_last   = pipe_l_q[LAT-1];
    pop         = out_valid_q & bus.ready_in;
    out_free    = ~out_valid_q | pop;
    store_rd    = out_free & (cnt_q != '0);
    store_wr    = push & ~(out_free & (cnt_q == '0));
    cnt_d       = cnt_q + CW'(store_wr) - CW'(store_rd);
    inflight_d  = inflight_q + CW'(en_q) - CW'(push);

    out_valid_d = out_free ? ((cnt_q != '0) | push) : 1'b1;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    if (store_rd) begin
      {out_last_d, out_data_d} = fifo_mem[rd_q];
    end else if (out_free && push) begin
      out_data_d = bus.ram_data_in;
      out_last_d = push_last;
    end

    // Credit looks at the counts as they will be registered in the issue cycle.
    credit_sum    = SW'(inflight_d) + SW'(cnt_d);
    credit_ok     = credit_sum < SW'(FIFO_DEPTH);
    fifo_overflow = store_wr & ~store_rd & (cnt_q == CW'(FIFO_DEPTH));
  end

  // Next-state and issue decision for the following cycle
  always_comb begin
    state_d    = state_q;
    issue_addr = next_addr_q;
    issue_left = rem_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start_in) begin
          issue_addr = bus.base_addr_in;
          issue_left = bus.len_in;
          state_d    = (bus.len_in == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (rem_q == '0) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (pop && out_last_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    en_d        = (state_d == ST_RUN) && (issue_left != '0) && credit_ok;
    last_iss_d  = en_d && (issue_left == LW'(1));
    rem_d       = issue_left - LW'(en_d);
    ram_addr_d  = en_d ? issue_addr : ram_addr_q;
    next_addr_d = en_d ? wrap_inc(issue_addr) : issue_addr;
  end

  // State, issue and FIFO control registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_IDLE;
      ram_addr_q  <= '0;
      next_addr_q <= '0;
      rem_q       <= '0;
      en_q        <= 1'b0;
      last_iss_q  <= 1'b0;
      pipe_v_q    <= '0;
      pipe_l_q    <= '0;
      inflight_q  <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ram_addr_q  <= ram_addr_d;
      next_addr_q <= next_addr_d;
      rem_q       <= rem_d;
      en_q        <= en_d;
      last_iss_q  <= last_iss_d;
      pipe_v_q[0] <= en_q;
      pipe_l_q[0] <= last_iss_q;
      for (int i = 1; i < int'(LAT); i++) begin
        pipe_v_q[i] <= pipe_v_q[i-1];
        pipe_l_q[i] <= pipe_l_q[i-1];
      end
      inflight_q  <= inflight_d;
      if (store_wr) wr_q <= wr_q + PW'(1);
      if (store_rd) rd_q <= rd_q + PW'(1);
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
    end
  end

  // FIFO storage carries {last, data}; contents need no reset
  always_ff @(posedge clk_in) begin
    if (store_wr) fifo_mem[wr_q] <= {push_last, bus.ram_data_in};
  end

  assert property (@(posedge clk_in) disable iff (rst_in) !fifo_overflow);

  assign bus.ram_addr_out  = ram_addr_q;
  assign bus.ram_en_out    = en_q;
  assign bus.ram_regce_out = 1'b1;
  assign bus.ram_we_out    = 1'b0;
  assign bus.data_out      = out_data_q;
  assign bus.valid_out     = out_valid_q;
  assign bus.last_out      = out_last_q;
  assign bus.busy_out      = busy_q;
  assign bus.done_out      = done_q;

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: two builds (latency 2 / FIFO 4 and latency 1 / FIFO 2) against a
// behavioural BRAM and an expected-word queue built from memory contents, base and length.
module tb_bram_stream_reader;

  localparam int unsigned RW    = 16;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam int          LAT_A = 2;
  localparam int          FD_A  = 4;
  localparam int          LAT_B = 1;
  localparam int          FD_B  = 2;

  logic clk;
  logic rst_a, rst_b;
  int   checks = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bram_stream_reader_if #(.RAM_WIDTH(RW), .AW(AW)) bus_a ();
  bram_stream_reader_if #(.RAM_WIDTH(RW), .AW(AW)) bus_b ();

  bram_stream_reader #(.RAM_WIDTH(RW), .RAM_DEPTH(DEPTH), .READ_LATENCY(LAT_A), .FIFO_DEPTH(FD_A))
    u_dut_a (.clk_in(clk), .rst_in(rst_a), .bus(bus_a));
  bram_stream_reader #(.RAM_WIDTH(RW), .RAM_DEPTH(DEPTH), .READ_LATENCY(LAT_B), .FIFO_DEPTH(FD_B))
    u_dut_b (.clk_in(clk), .rst_in(rst_b), .bus(bus_b));

  // Behavioural BRAM: address register stage, then optional output register
  logic [RW-1:0] mem [DEPTH];
  logic [RW-1:0] a_r0, a_r1, b_r0;
  always @(posedge clk) begin
    if (bus_a.ram_en_out && !bus_a.ram_we_out) a_r0 <= mem[bus_a.ram_addr_out];
    if (bus_a.ram_regce_out) a_r1 <= a_r0;
    if (bus_b.ram_en_out && !bus_b.ram_we_out) b_r0 <= mem[bus_b.ram_addr_out];
  end
  assign bus_a.ram_data_in = a_r1;
  assign bus_b.ram_data_in = b_r0;

  logic          s_valid, s_last, s_en, s_busy, s_done, s_regce, s_we;
  logic [RW-1:0] s_data;
  logic [AW-1:0] s_addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic sample(input int sel);
    if (sel == 0) begin
      s_valid = bus_a.valid_out; s_last = bus_a.last_out; s_en = bus_a.ram_en_out;
      s_busy = bus_a.busy_out; s_done = bus_a.done_out; s_regce = bus_a.ram_regce_out;
      s_we = bus_a.ram_we_out; s_data = bus_a.data_out; s_addr = bus_a.ram_addr_out;
    end else begin
      s_valid = bus_b.valid_out; s_last = bus_b.last_out; s_en = bus_b.ram_en_out;
      s_busy = bus_b.busy_out; s_done = bus_b.done_out; s_regce = bus_b.ram_regce_out;
      s_we = bus_b.ram_we_out; s_data = bus_b.data_out; s_addr = bus_b.ram_addr_out;
    end
  endtask

  task automatic drive(input int sel, input logic st, input int b, input int l, input logic rdy);
    if (sel == 0) begin
      bus_a.start_in = st; bus_a.base_addr_in = AW'(b); bus_a.len_in = (AW+1)'(l); bus_a.ready_in = rdy;
    end else begin
      bus_b.start_in = st; bus_b.base_addr_in = AW'(b); bus_b.len_in = (AW+1)'(l); bus_b.ready_in = rdy;
    end
  endtask

  task automatic check_reset(input int sel);
    sample(sel);
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_en",    32'(s_en),    32'd0);
    check("rst_busy",  32'(s_busy),  32'd0);
    check("rst_done",  32'(s_done),  32'd0);
    check("rst_last",  32'(s_last),  32'd0);
    check("rst_data",  32'(s_data),  32'd0);
    check("rst_addr",  32'(s_addr),  32'd0);
    check("rst_regce", 32'(s_regce), 32'd1);
    check("rst_we",    32'(s_we),    32'd0);
  endtask

  function automatic logic pat(input int c);
    return (c % 4 == 0) || (c % 4 == 3);
  endfunction

  // mode: 0 ready=1, 1 pattern 1,0,0,1, 2 random, 3 pattern with a 20-cycle stall
  task automatic run_burst(input int sel, input int base, input int len, input int mode,
                           input bit poke, input int rst_after);
    int lat, fd, issued, xfers, first_en, first_val, first_x, last_x, done_cyc;
    logic rdy;
    logic [RW-1:0] exp_q [$];
    lat = (sel == 0) ? LAT_A : LAT_B;
    fd  = (sel == 0) ? FD_A : FD_B;
    for (int k = 0; k < len; k++) exp_q.push_back(mem[(base + k) % DEPTH]);
    issued = 0; xfers = 0; first_en = -1; first_val = -1; first_x = -1; last_x = -1; done_cyc = -1;
    @(negedge clk);
    drive(sel, 1'b1, base, len, 1'b1);
    for (int cyc = 1; cyc < 300 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      sample(sel);
      case (mode)
        1:       rdy = pat(cyc);
        2:       rdy = ($urandom_range(0, 2) != 0);
        3:       rdy = (cyc >= 4 && cyc < 24) ? 1'b0 : pat(cyc);
        default: rdy = 1'b1;
      endcase
      if (poke && cyc == 2) drive(sel, 1'b1, base + 3, 3, rdy);
      else                  drive(sel, 1'b0, base, len, rdy);
      if (cyc == 1) check("busy_start", 32'(s_busy), 32'd1);
      if (s_en) begin
        if (first_en < 0) first_en = cyc;
        check("addr", 32'(s_addr), 32'((base + issued) % DEPTH));
        issued++;
        check("en_beyond_len", 32'(issued <= len), 32'd1);
        // outstanding words fit in FIFO storage plus the output register
        check("outstanding", 32'(issued - xfers <= fd + 1), 32'd1);
      end
      if (s_valid) begin
        if (first_val < 0) first_val = cyc;
        if (rdy) begin
          if (exp_q.size() == 0) check("word_count", 32'(xfers + 1), 32'(len));
          else begin
            check("data", 32'(s_data), 32'(exp_q.pop_front()));
            check("last", 32'(s_last), 32'(exp_q.size() == 0));
          end
          xfers++;
          if (first_x < 0) first_x = cyc;
          last_x = cyc;
        end
      end
      if (s_done) done_cyc = cyc;
      if (rst_after > 0 && xfers == rst_after) begin
        @(posedge clk);
        #2;
        if (sel == 0) rst_a = 1'b1; else rst_b = 1'b1;
        #1;
        check_reset(sel);
        drive(sel, 1'b0, 0, 0, 1'b1);
        return;
      end
    end
    check("done_seen", 32'(done_cyc >= 0), 32'd1);
    check("done_cycle", 32'(done_cyc), 32'((len == 0) ? 1 : last_x + 1));
    check("xfers", 32'(xfers), 32'(len));
    check("issued", 32'(issued), 32'(len));
    if (mode == 0 && len > 0) begin
      check("first_latency", 32'(first_val - first_en), 32'(lat + 1));
      check("stream_span", 32'(last_x - first_x), 32'(len - 1));
    end
    @(negedge clk);
    sample(sel);
    check("busy_after", 32'(s_busy), 32'd0);
    check("done_width", 32'(s_done), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = RW'(i);
    rst_a = 1'b1;
    rst_b = 1'b1;
    drive(0, 1'b0, 0, 0, 1'b1);
    drive(1, 1'b0, 0, 0, 1'b1);
    repeat (3) @(negedge clk);
    check_reset(0);
    check_reset(1);
    rst_a = 1'b0;
    rst_b = 1'b0;

    run_burst(0, 0, 8, 0, 1'b0, 0);
    run_burst(0, 14, 4, 0, 1'b0, 0);
    run_burst(0, 0, 10, 1, 1'b0, 0);
    run_burst(0, 3, 10, 3, 1'b0, 0);
    run_burst(0, 5, 0, 0, 1'b0, 0);
    run_burst(0, 2, 5, 0, 1'b1, 0);

    // reset in the middle of a burst, then confirm stale returns never surface
    run_burst(0, 0, 8, 0, 1'b0, 3);
    @(negedge clk);
    check_reset(0);
    rst_a = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      sample(0);
      check("stale_valid", 32'(s_valid), 32'd0);
    end
    run_burst(0, 4, 2, 0, 1'b0, 0);

    run_burst(1, 0, 6, 0, 1'b0, 0);
    run_burst(1, 13, 7, 1, 1'b0, 0);

    for (int i = 0; i < int'(DEPTH); i++) mem[i] = RW'($urandom);
    for (int n = 0; n < 40; n++) begin
      int sel, base, len, mode;
      bit poke;
      sel  = int'($urandom_range(0, 1));
      base = int'($urandom_range(0, DEPTH - 1));
      len  = int'($urandom_range(0, DEPTH));
      mode = int'($urandom_range(0, 3));
      poke = (len > 0) && ($urandom_range(0, 3) == 0);
      run_burst(sel, base, len, mode, poke, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
